// File: rtl/error_metrics_pkg.sv
// Shared types and width helpers for the approximate-sqrt error metric blocks.
package error_metrics_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DIV,
        ST_DONE
    } state_t;

    // One quotient bit per cycle, so the stall equals the quotient width.
    function automatic int div_cyc(input int out_w, input int frac_w);
        return out_w + frac_w;
    endfunction

    function automatic int sad_w(input int cnt_w, input int out_w);
        return cnt_w + out_w;
    endfunction

    function automatic int red_w(input int cnt_w, input int out_w, input int frac_w);
        return cnt_w + out_w + frac_w;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; the first bit is
// resolved on the start edge so done rises N_W-1 cycles after start.
module seq_divider #(
    parameter int N_W = 24,
    parameter int D_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] quotient
);

    localparam int CW = $clog2(N_W + 1);

    logic [N_W-1:0] dvd;
    logic [D_W-1:0] dvs;
    logic [D_W-1:0] rem;
    logic [N_W-1:0] quo;
    logic [CW-1:0]  cnt;

    logic [D_W-1:0] rem_src;
    logic [D_W-1:0] dvs_src;
    logic           bit_src;
    logic [D_W:0]   shifted;
    logic [D_W:0]   diff;
    logic           qbit;
    logic [D_W-1:0] rem_nxt;

    always_comb begin
        rem_src = start ? '0 : rem;
        dvs_src = start ? divisor : dvs;
        bit_src = start ? dividend[N_W-1] : dvd[N_W-1];
        shifted = {rem_src, bit_src};
        diff    = shifted - {1'b0, dvs_src};
        qbit    = ~diff[D_W];
        rem_nxt = qbit ? diff[D_W-1:0] : shifted[D_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            done <= 1'b0;
            cnt  <= CW'(1);
        end else if (busy) begin
            if (cnt == CW'(N_W - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            cnt <= cnt + CW'(1);
        end else begin
            done <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            dvs <= divisor;
            dvd <= {dividend[N_W-2:0], 1'b0};
            rem <= rem_nxt;
            quo <= {{(N_W-1){1'b0}}, qbit};
        end else if (busy) begin
            dvd <= {dvd[N_W-2:0], 1'b0};
            rem <= rem_nxt;
            quo <= {quo[N_W-2:0], qbit};
        end
    end

    assign quotient = quo;

endmodule

// File: rtl/error_metrics_accum.sv
// Streaming accumulator of ER/NMED/MRED raw totals over (exact, approx) pairs;
// samples with a nonzero error and nonzero reference stall for a divide.
module error_metrics_accum
    import error_metrics_pkg::*;
#(
    parameter int OUT_W  = 8,
    parameter int CNT_W  = 17,
    parameter int FRAC_W = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [OUT_W-1:0]                      ref_val,
    input  logic [OUT_W-1:0]                      approx_val,
    input  logic                                  in_last,
    output logic                                  done,
    output logic [CNT_W-1:0]                      sample_count,
    output logic [CNT_W-1:0]                      err_count,
    output logic [sad_w(CNT_W, OUT_W)-1:0]        sad_sum,
    output logic [OUT_W-1:0]                      ed_max,
    output logic [red_w(CNT_W, OUT_W, FRAC_W)-1:0] red_sum
);

    localparam int Q_W   = div_cyc(OUT_W, FRAC_W);
    localparam int SAD_W = sad_w(CNT_W, OUT_W);
    localparam int RED_W = red_w(CNT_W, OUT_W, FRAC_W);

    state_t           state;
    logic             last_q;
    logic [OUT_W-1:0] abs_diff;
    logic             accept;
    logic             need_div;
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [Q_W-1:0]   quotient;

    always_comb begin
        abs_diff  = (ref_val >= approx_val) ? (ref_val - approx_val) : (approx_val - ref_val);
        accept    = (state == ST_RUN) && in_valid && in_ready;
        need_div  = (abs_diff != '0) && (ref_val != '0);
        div_start = accept && need_div && !div_busy;
    end

    seq_divider #(
        .N_W(Q_W),
        .D_W(OUT_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend ({abs_diff, {FRAC_W{1'b0}}}),
        .divisor  (ref_val),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            in_ready     <= 1'b0;
            done         <= 1'b0;
            last_q       <= 1'b0;
            sample_count <= '0;
            err_count    <= '0;
            sad_sum      <= '0;
            ed_max       <= '0;
            red_sum      <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        sample_count <= '0;
                        err_count    <= '0;
                        sad_sum      <= '0;
                        ed_max       <= '0;
                        red_sum      <= '0;
                        done         <= 1'b0;
                        in_ready     <= 1'b1;
                        state        <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (!(&sample_count))
                            sample_count <= sample_count + CNT_W'(1);
                        if (abs_diff != '0 && !(&err_count))
                            err_count <= err_count + CNT_W'(1);
                        sad_sum <= sad_sum + SAD_W'(abs_diff);
                        if (abs_diff > ed_max)
                            ed_max <= abs_diff;
                        last_q <= in_last;
                        if (need_div) begin
                            in_ready <= 1'b0;
                            state    <= ST_DIV;
                        end else if (in_last) begin
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        red_sum <= red_sum + RED_W'(quotient);
                        if (last_q) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= ST_RUN;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
